fetch_stage: RTL

Fetch stage plus IF/ID pipeline register for the 5-stage cached RV32I core. Holds PCF and issues one blocking request at a time to the instruction cache (multi-cycle on miss). Applies branch/jump redirects from Execute. Honours StallFetch/StallDecode/FlushDecode from the hazard unit and drives Decode with InstrD/PCD/PCPlus4D.

---
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-cache handshake between the fetch stage (master) and the I-cache (slave).
// One blocking request at a time: ImemReq/ImemAddr hold until the ImemValid pulse.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemValid;

  modport master (output ImemReq, output ImemAddr, input ImemRdata, input ImemValid);
  modport slave  (input ImemReq, input ImemAddr, output ImemRdata, output ImemValid);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID pipeline register for the 5-stage cached RV32I core.
// FETCH issues to the I-cache, KILL drains a redirected miss, HOLD parks a fetched word during a stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          StallFetch,
  input  logic          StallDecode,
  input  logic          FlushDecode,
  input  logic [1:0]    PCSrcE,
  input  logic [31:0]   PCTargetE,
  input  logic [31:0]   ALUResultE,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD
);

  typedef enum logic [1:0] {S_FETCH, S_KILL, S_HOLD} state_t;

  state_t      r_state_p0;
  logic        r_req_p0;
  logic [31:0] r_pc_p0;
  logic [31:0] r_buf_p0;
  logic [31:0] r_redir_pc_p0;

  logic [31:0] r_instr_p1;
  logic [31:0] r_pcd_p1;
  logic [31:0] r_pc4_p1;
  logic        r_vld_p1;

  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_hold;
  logic        w_deliver;
  logic [31:0] w_dlv_instr;

  assign w_redir    = (PCSrcE != 2'b00);
  assign w_target   = (PCSrcE == 2'b10) ? (ALUResultE & ~32'h1) : PCTargetE;
  assign w_pc_plus4 = r_pc_p0 + 32'd4;
  // StallDecode always comes with StallFetch; folding both in guarantees a suppressed delivery is parked, not lost
  assign w_hold     = StallFetch | StallDecode;

  always_comb begin
    w_deliver   = 1'b0;
    w_dlv_instr = imem.ImemRdata;
    if (r_state_p0 == S_FETCH) begin
      w_deliver = imem.ImemValid & ~w_redir & ~w_hold;
    end else if (r_state_p0 == S_HOLD) begin
      w_deliver   = ~w_redir & ~w_hold;
      w_dlv_instr = r_buf_p0;
    end
  end

  // ---- stage p0: PC / request FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_p0    <= S_FETCH;
      r_req_p0      <= 1'b1;
      r_pc_p0       <= RESET_PC;
      r_buf_p0      <= 32'h0;
      r_redir_pc_p0 <= 32'h0;
    end else begin
      case (r_state_p0)
        S_FETCH: begin
          if (imem.ImemValid) begin
            if (w_redir) begin
              r_pc_p0 <= w_target;
            end else if (w_hold) begin
              r_buf_p0   <= imem.ImemRdata;
              r_state_p0 <= S_HOLD;
              r_req_p0   <= 1'b0;
            end else begin
              r_pc_p0 <= w_pc_plus4;
            end
          end else if (w_redir) begin
            // the cache still owns the old address, so remember the target and wait it out
            r_redir_pc_p0 <= w_target;
            r_state_p0    <= S_KILL;
          end
        end
        S_KILL: begin
          if (imem.ImemValid) begin
            r_pc_p0    <= w_redir ? w_target : r_redir_pc_p0;
            r_state_p0 <= S_FETCH;
          end else if (w_redir) begin
            r_redir_pc_p0 <= w_target;
          end
        end
        S_HOLD: begin
          if (w_redir) begin
            r_pc_p0    <= w_target;
            r_state_p0 <= S_FETCH;
            r_req_p0   <= 1'b1;
          end else if (!w_hold) begin
            r_pc_p0    <= w_pc_plus4;
            r_state_p0 <= S_FETCH;
            r_req_p0   <= 1'b1;
          end
        end
        default: begin
          r_state_p0 <= S_FETCH;
          r_req_p0   <= 1'b1;
        end
      endcase
    end
  end

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_p1 <= NOP_INSTR;
      r_pcd_p1   <= 32'h0;
      r_pc4_p1   <= 32'h0;
      r_vld_p1   <= 1'b0;
    end else if (FlushDecode) begin
      r_instr_p1 <= NOP_INSTR;
      r_pcd_p1   <= 32'h0;
      r_pc4_p1   <= 32'h0;
      r_vld_p1   <= 1'b0;
    end else if (!StallDecode) begin
      if (w_deliver) begin
        r_instr_p1 <= w_dlv_instr;
        r_pcd_p1   <= r_pc_p0;
        r_pc4_p1   <= w_pc_plus4;
        r_vld_p1   <= 1'b1;
      end else begin
        r_instr_p1 <= NOP_INSTR;
        r_pcd_p1   <= 32'h0;
        r_pc4_p1   <= 32'h0;
        r_vld_p1   <= 1'b0;
      end
    end
  end

  assign imem.ImemReq  = r_req_p0;
  assign imem.ImemAddr = r_pc_p0;
  assign InstrD        = r_instr_p1;
  assign PCD           = r_pcd_p1;
  assign PCPlus4D      = r_pc4_p1;
  assign ValidD        = r_vld_p1;

endmodule
